mix_columns_seq: RTL and testbench
==================================

Name: mix_columns_seq

Overview:
- Forward AES MixColumns engine for the encryption datapath. It is the counterpart of the decryption-side inverse MixColumns helper.
- Accepts one 128-bit state over a valid/ready handshake and processes it column by column.
- Uses a small FSM and a column counter, then holds the result until the downstream stage accepts it.
- Sits between ShiftRows and AddRoundKey in rounds 1..13 of the AES-256 round pipeline.

Parameters:
- COLS_PER_CYCLE, default 1: columns transformed per CALC cycle. Legal values are 1, 2, 4; any other value is a synthesis-time error.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  state_in is valid
- in_ready  output  1  block can accept a state this cycle
- state_in  input  128  input state; column c = state_in[127-32c -: 32], row 0 byte is the MSB of the column
- out_valid  output  1  state_out holds a completed result
- out_ready  input  1  downstream accepts state_out
- state_out  output  128  MixColumns result, same byte ordering as state_in
- busy  output  1  high in CALC state

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, col_cnt=0, in_ready=1, out_valid=0, busy=0, state_out=128'h0, internal input register=0.
- Reset mid-operation: rst asserted in any state aborts immediately to the reset values. The partial result is discarded and no out_valid pulse is produced.
- FSM states: IDLE, CALC, DONE.
  - IDLE: in_ready=1. On in_valid&in_ready, capture state_in into in_reg, set col_cnt=0, go to CALC.
  - CALC: in_ready=0, busy=1.
    - Each cycle, transform columns col_cnt .. col_cnt+COLS_PER_CYCLE-1 from in_reg and write them into the same positions of the result register.
    - col_cnt += COLS_PER_CYCLE.
    - When the last column is written, go to DONE.
    - in_valid is ignored while in CALC.
  - DONE: out_valid=1, and state_out is stable until accepted.
    - out_ready=1 without a new input: go to IDLE, out_valid drops next cycle.
    - out_ready=0: hold state, out_valid and state_out (no data change while stalled).
    - Back-to-back: in_ready = out_ready in DONE. If out_ready&in_valid, the old result is consumed and the new state is captured on the same edge; go directly to CALC.
- Latency: accept edge T gives out_valid high after edge T + 4/COLS_PER_CYCLE (4, 2 or 1 cycles).
- Throughput: one state per 4/COLS_PER_CYCLE + 1 cycles with back-to-back acceptance.
- Column arithmetic over GF(2^8), per column bytes a0..a3:
  - b0 = 2·a0 ^ 3·a1 ^ a2 ^ a3
  - b1 = a0 ^ 2·a1 ^ 3·a2 ^ a3
  - b2 = a0 ^ a1 ^ 2·a2 ^ 3·a3
  - b3 = 3·a0 ^ a1 ^ a2 ^ 2·a3
  - xtime(a) = {a[6:0],1'b0} ^ (a[7] ? 8'h1b : 8'h00); 3·a = xtime(a) ^ a. All results are 8-bit, no carries.
  - No lookup tables; the logic is purely xtime/XOR.
- col_cnt: 2 bits. It wraps to 0 on the transition to DONE and never indexes beyond column 3.
- state_out is driven only from the result register, never combinationally from state_in.

Test Plan:
- Reset then single state: state_in = db135345_f20a225c_01010101_c6c6c6c6 -> after 4 cycles out_valid=1, state_out = 8e4da1bc_9fdc589d_01010101_c6c6c6c6. in_ready=0 throughout CALC.
- xtime overflow: state_in = d4d4d4d5_2d26314c_80808080_ffffffff -> state_out = d5d5d7d6_4d7ebdf8_80808080_ffffffff. Repeat with COLS_PER_CYCLE=2 and 4 and check latencies of 2 and 1 cycles respectively.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. Required: state_out and out_valid stable, in_ready=0, and an in_valid pulse is not accepted. Then release out_ready -> one transfer, return to IDLE.
- Back-to-back: in_valid held high with two vectors and out_ready=1. Required: second vector accepted on the same edge the first result is consumed; second result correct; no bubble beyond the 4 CALC cycles.
- Reset mid-CALC: assert rst asynchronously at col_cnt=2 -> outputs go immediately to reset values, no out_valid. The next input after deassertion produces the correct result.
- Random regression: 10k random states checked against a reference model. Apply the inverse MixColumns helper to state_out and require the original state_in back.

Source files
------------

// File: rtl/mix_columns_seq_if.sv
// Handshake bundle between the ShiftRows side, the MixColumns engine and the AddRoundKey side.
// No latency of its own: wires only.
// The master drives in_valid/state_in/out_ready; the slave (engine) answers with ready/valid/result/busy.
interface mix_columns_seq_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;
    logic         busy;

    modport master (
        output in_valid, state_in, out_ready,
        input  in_ready, out_valid, state_out, busy
    );

    modport slave (
        input  in_valid, state_in, out_ready,
        output in_ready, out_valid, state_out, busy
    );
endinterface

// File: rtl/mix_columns_seq.sv
// Forward AES MixColumns, COLS_PER_CYCLE columns per CALC cycle over a registered copy of the input.
// Latency: accept edge T -> out_valid after edge T + 4/COLS_PER_CYCLE.
// Result held in DONE until out_ready; in_ready follows out_ready in DONE for back-to-back transfers.
module mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    mix_columns_seq_if.slave bus
);

    generate
        if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
            $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Column counter step and the counter value on which the last column group is written.
    localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] COL_LAST = 2'(4 - COLS_PER_CYCLE);

    state_t       state;
    state_t       state_nxt;
    logic [1:0]   col_cnt;
    logic [127:0] in_reg;
    logic [127:0] res_reg;
    logic [127:0] res_nxt;
    logic         load;
    logic         calc;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // One column: row 0 byte in the MSB position.
    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        b0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
        b3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake outputs; DONE accepts a new state on the edge that hands off the old one.
    always_comb begin
        state_nxt     = state;
        load          = 1'b0;
        calc          = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    load      = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                bus.busy = 1'b1;
                calc     = 1'b1;
                if (col_cnt == COL_LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                bus.in_ready  = bus.out_ready;
                if (bus.out_ready) begin
                    if (bus.in_valid) begin
                        load      = 1'b1;
                        state_nxt = CALC;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Transform the current column group in place; untouched columns keep their previous value.
    always_comb begin
        logic [1:0] idx;
        idx     = 2'd0;
        res_nxt = res_reg;
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
            idx = col_cnt + 2'(j);
            res_nxt[32*(3-int'(idx)) +: 32] = mix_col(in_reg[32*(3-int'(idx)) +: 32]);
        end
    end

    // Input capture, column counter and result register; the counter wraps to 0 as the last group lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_reg  <= 128'h0;
            col_cnt <= 2'd0;
            res_reg <= 128'h0;
        end else if (load) begin
            in_reg  <= bus.state_in;
            col_cnt <= 2'd0;
        end else if (calc) begin
            res_reg <= res_nxt;
            col_cnt <= col_cnt + COL_STEP;
        end
    end

    assign bus.state_out = res_reg;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Bench for mix_columns_seq with one instance per legal COLS_PER_CYCLE (1, 2, 4).
// Reference model is a plain GF(2^8) matrix product with a generic polynomial multiply.
// Inputs are driven #1 after the rising edge, outputs sampled at the same point.
module tb_mix_columns_seq;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mix_columns_seq_if bus0 ();
    mix_columns_seq_if bus1 ();
    mix_columns_seq_if bus2 ();

    mix_columns_seq #(.COLS_PER_CYCLE(1)) u0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    mix_columns_seq #(.COLS_PER_CYCLE(2)) u1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    mix_columns_seq #(.COLS_PER_CYCLE(4)) u2 (.clk(clk), .rst(rst), .bus(bus2.slave));

    logic [2:0]   iv;
    logic [2:0]   ordy;
    logic [127:0] si [3];
    logic [2:0]   ov;
    logic [2:0]   ir;
    logic [2:0]   by;
    logic [127:0] so [3];

    assign bus0.in_valid  = iv[0];
    assign bus1.in_valid  = iv[1];
    assign bus2.in_valid  = iv[2];
    assign bus0.out_ready = ordy[0];
    assign bus1.out_ready = ordy[1];
    assign bus2.out_ready = ordy[2];
    assign bus0.state_in  = si[0];
    assign bus1.state_in  = si[1];
    assign bus2.state_in  = si[2];
    assign ov    = {bus2.out_valid, bus1.out_valid, bus0.out_valid};
    assign ir    = {bus2.in_ready,  bus1.in_ready,  bus0.in_ready};
    assign by    = {bus2.busy,      bus1.busy,      bus0.busy};
    assign so[0] = bus0.state_out;
    assign so[1] = bus1.state_out;
    assign so[2] = bus2.state_out;

    int checks   = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input int b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ ({8'h00, a} << i);
        for (int i = 14; i >= 8; i--)
            if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [127:0] mat_apply(input logic [127:0] s, input bit inverse);
        int coef [4];
        logic [127:0] r;
        logic [7:0] acc;
        if (inverse) coef = '{14, 11, 13, 9};
        else         coef = '{2, 3, 1, 1};
        r = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(s[127 - 32*c - 8*j -: 8], coef[(j - row + 4) % 4]);
                r[127 - 32*c - 8*row -: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] mc_ref(input logic [127:0] s);
        return mat_apply(s, 1'b0);
    endfunction

    function automatic logic [127:0] imc_ref(input logic [127:0] s);
        return mat_apply(s, 1'b1);
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send one state on instance k, measure latency, optionally stall, then consume the result.
    task automatic do_xfer(input int k, input logic [127:0] din, input logic [127:0] exp,
                           input int hold, input string tag);
        int  n;
        bit  calc_ok;
        bit  stall_ok;
        n = 0;
        ordy[k] = 1'b0;
        si[k]   = din;
        iv[k]   = 1'b1;
        while (!ir[k] && n < 50) begin
            tick();
            n++;
        end
        tick();
        iv[k]   = 1'b0;
        si[k]   = rand128();
        n       = 0;
        calc_ok = 1'b1;
        while (!ov[k] && n < 50) begin
            if (ir[k] || !by[k]) calc_ok = 1'b0;
            tick();
            n++;
        end
        chk({tag, "_latency"}, 128'(n), 128'(4 >> k));
        chk({tag, "_calc_flags"}, 128'(calc_ok), 128'd1);
        chk({tag, "_result"}, so[k], exp);
        chk({tag, "_model"}, so[k], mc_ref(din));
        stall_ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            iv[k] = (i == 3);
            si[k] = rand128();
            tick();
            if (!ov[k] || ir[k] || by[k] || so[k] !== exp) stall_ok = 1'b0;
        end
        iv[k] = 1'b0;
        if (hold > 0) chk({tag, "_stall_stable"}, 128'(stall_ok), 128'd1);
        ordy[k] = 1'b1;
        tick();
        ordy[k] = 1'b0;
        chk({tag, "_idle_after"}, {125'h0, ov[k], ir[k], by[k]}, 128'b010);
    endtask

    // Stream count random states with in_valid and out_ready held high.
    task automatic stream(input int k, input int count);
        logic [127:0] q [$];
        logic [127:0] e;
        int sent;
        int guard;
        sent  = 0;
        guard = 0;
        ordy[k] = 1'b1;
        si[k]   = rand128();
        iv[k]   = 1'b1;
        while ((sent < count || q.size() > 0) && guard < count * 8 + 100) begin
            if (ov[k]) begin
                chk("rand_order", 128'(q.size() > 0), 128'd1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("rand_model", so[k], mc_ref(e));
                    chk("rand_inverse", imc_ref(so[k]), e);
                end
            end
            if (iv[k] && ir[k]) begin
                q.push_back(si[k]);
                sent++;
            end
            tick();
            guard++;
            if (sent < count) si[k] = rand128();
            else              iv[k] = 1'b0;
        end
        chk("rand_sent", 128'(sent), 128'(count));
        chk("rand_drained", 128'(q.size()), 128'd0);
        ordy[k] = 1'b0;
        iv[k]   = 1'b0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin : main
        int n;
        bit ok;
        logic [127:0] va, vb;
        rst  = 1'b1;
        iv   = 3'b000;
        ordy = 3'b000;
        for (int k = 0; k < 3; k++) si[k] = 128'h0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("reset_flags", {125'h0, ov[k], ir[k], by[k]}, 128'b010);
            chk("reset_state_out", so[k], 128'h0);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Known vectors, with a 10-cycle stall on the first.
        do_xfer(0, 128'hdb135345_f20a225c_01010101_c6c6c6c6,
                   128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 10, "vec1_c1");
        do_xfer(0, 128'hd4d4d4d5_2d26314c_80808080_ffffffff,
                   128'hd5d5d7d6_4d7ebdf8_80808080_ffffffff, 0, "ovf_c1");
        do_xfer(1, 128'hd4d4d4d5_2d26314c_80808080_ffffffff,
                   128'hd5d5d7d6_4d7ebdf8_80808080_ffffffff, 0, "ovf_c2");
        do_xfer(2, 128'hd4d4d4d5_2d26314c_80808080_ffffffff,
                   128'hd5d5d7d6_4d7ebdf8_80808080_ffffffff, 4, "ovf_c4");

        // Back-to-back on the 1-column instance.
        va = rand128();
        vb = rand128();
        ordy[0] = 1'b1;
        si[0]   = va;
        iv[0]   = 1'b1;
        tick();
        si[0] = vb;
        n = 0;
        while (!ov[0] && n < 50) begin
            tick();
            n++;
        end
        chk("b2b_first_latency", 128'(n), 128'd4);
        chk("b2b_first_result", so[0], mc_ref(va));
        chk("b2b_overlap_ready", 128'(ir[0]), 128'd1);
        tick();
        iv[0] = 1'b0;
        chk("b2b_second_accepted", {126'h0, ov[0], by[0]}, 128'b01);
        n = 0;
        while (!ov[0] && n < 50) begin
            tick();
            n++;
        end
        chk("b2b_second_latency", 128'(n), 128'd4);
        chk("b2b_second_result", so[0], mc_ref(vb));
        tick();
        ordy[0] = 1'b0;
        chk("b2b_idle", {125'h0, ov[0], ir[0], by[0]}, 128'b010);

        // Asynchronous reset two cycles into CALC.
        si[0] = rand128();
        iv[0] = 1'b1;
        tick();
        iv[0] = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("midrst_flags", {125'h0, ov[0], ir[0], by[0]}, 128'b010);
        chk("midrst_state_out", so[0], 128'h0);
        #2;
        rst = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ov[0] || !ir[0]) ok = 1'b0;
        end
        chk("midrst_no_out_valid", 128'(ok), 128'd1);
        va = rand128();
        do_xfer(0, va, mc_ref(va), 0, "after_rst");

        // Random regression across all three widths.
        stream(0, 4000);
        stream(1, 3000);
        stream(2, 3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
